hex_keypad: RTL and testbench
=============================

# hex_keypad

Scanning reader for a 4x4 hexadecimal matrix keypad; it is the input-side counterpart of the board's multiplexed hex display. It drives one keypad row low at a time, samples the four column lines, debounces the per-frame result and turns each new key press into a 4-bit code. Each accepted code is also shifted into a 16-bit digit register that feeds the display's `data` input directly, so typed digits scroll in from the right.

## Interface
- `SCAN_DIV`, 1000: clock cycles each row is driven; must be >= 4.
- `DEBOUNCE`, 4: consecutive identical frames required to accept a result; range 1..15.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cols` in 4: keypad column lines; active-low, externally pulled up, asynchronous to `clk`.
- `clear` in 1: synchronous request to zero `data`.
- `rows` out 4: keypad row drive; exactly one bit is low, the rest are high.
- `data` out 16: last four accepted codes; the newest code is in `[3:0]`.
- `key_code` out 4: most recently accepted code.
- `key_valid` out 1: one-cycle pulse marking a newly accepted key.
- `key_held` out 1: high while an accepted key has not yet been released.

## Operation
- **Synchronizer:** `cols` passes through a 2-flop synchronizer before any use.
- **Row scan:** a row index `r` (0..3) selects the driven row, with `rows = ~(4'b1 << r)`.
  - A dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle the synchronized columns are sampled for row `r`, then `r` increments, wrapping 3 -> 0.
- **Frame:** rows 0..3 form one frame of 4*SCAN_DIV cycles. Each frame produces one result:
  - NONE: no low column in any row.
  - KEY(code): exactly one low bit across all 16 samples; `code = {r[1:0], c[1:0]}`, where `c` is the index of the low column.
  - MULTI: two or more low bits.
- **Debounce:** at each frame end the result is compared with the previous frame's result.
  - Equal: the stable counter increments, saturating at DEBOUNCE.
  - Different: the stable counter is set to 1.
  - A result is stable when the counter equals DEBOUNCE.
- **Acceptance:** the block tracks `last_key`, which is either NONE or a code.
  - Stable KEY(k) with `k != last_key`: pulse `key_valid`, set `key_code <= k`, `data <= {data[11:0], k}`, `last_key <= k`, `key_held <= 1`.
  - Stable KEY(k) with `k == last_key`: no action. There is no auto-repeat.
  - Stable NONE: `last_key <= NONE`, `key_held <= 0`.
  - Stable MULTI: no change to any state.
- **Clear:** `clear` sets `data <= 0` on the next edge.
  - If `clear` and an acceptance fall in the same cycle, `data <= {12'h0, k}`.
  - `clear` does not affect `key_code`, `key_held` or the scan.

## Timing
- **Reset values:** `rows = 4'b1110`, `data = 0`, `key_code = 0`, `key_valid = 0`, `key_held = 0`.
  - Internally: `r = 0`, dwell counter 0, synchronizer flops all 1, stable counter 0, previous result NONE, `last_key` NONE.
- **Reset mid-frame:** the partial frame is discarded and scanning restarts at row 0.
- **Settling:** row `r` is driven for SCAN_DIV cycles. Because the sample is taken on the last dwell cycle, the 2-cycle synchronizer has settled.
- **Acceptance latency:** for a key pressed cleanly before a frame starts, `key_valid`, `key_code`, `data` and `key_held` all update on the cycle after the last sample of the DEBOUNCE-th identical frame. That is DEBOUNCE*4*SCAN_DIV + 1 cycles after that frame's first cycle.
- **Pulse width:** `key_valid` is high for exactly one cycle.
- **Release latency:** `key_held` falls on the cycle after the DEBOUNCE-th consecutive NONE frame ends.
- **Bounce:** a change mid-debounce restarts the count at 1, so there is no partial acceptance.
- **Direct change A -> B:** holding B alone for DEBOUNCE frames accepts B without an intervening release.
- **Multi-key sequence:** A -> A+B -> A produces no second A, because MULTI does not reset `last_key`.

## Structure
- **Package `hex_keypad_pkg`:**
  - constants `ROWS = 4`, `COLS = 4`;
  - a result-kind enum {NONE, KEY, MULTI};
  - a scan-result struct holding the kind plus a 4-bit code.
- **Sub-module `key_debounce`:** takes a per-frame result and a frame strobe; produces the stable result and a stable strobe. It holds the stable counter and the previous result.
- **Top level:** the synchronizer, row/dwell counters, frame accumulation, acceptance logic and the `data` shift register stay in the top.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=2, giving a 16-cycle frame.
- **Scan pattern:** no key pressed -> `rows` cycles 1110, 1101, 1011, 0111, changing every 4 cycles; `key_valid` never rises and `data` stays 0.
- **Single key, no repeat:** key at row 2, col 1 held 5 frames -> one `key_valid` pulse at the end of frame 2 (cycle 33 from frame start); `key_code = 4'h9`, `data = 16'h0009`, `key_held = 1`, and no further pulses.
- **Digit sequence:** press and release keys 1, 2, 3, 4, 5 in turn, each held and released for 3 frames -> five pulses; final `data = 16'h2345`; `key_held` returns to 0 two frames after the last release.
- **Bounce and multi-key:** key toggled every frame for 6 frames -> no pulse. Two keys held together -> no pulse. Then one of the two released -> no pulse if it is the same key as before the overlap, a pulse if it is a different key.
- **Clear / reset:**
  - `clear` asserted on the same cycle as acceptance of key 7, with `data = 16'hABCD` -> `data = 16'h0007`.
  - `rst_n` pulsed low mid-frame -> all outputs return to reset values immediately, and `rows = 4'b1110` on release.

Source files
------------

// File: rtl/hex_keypad_pkg.sv
// Shared types and helpers for the hex keypad scanner: per-frame scan result
// kinds and column-bit utilities.
package hex_keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    NONE,
    KEY,
    MULTI
  } result_kind_t;

  typedef struct packed {
    result_kind_t kind;
    logic [3:0]   code;
  } scan_result_t;

  // Number of active-low (pressed) columns in one row sample.
  function automatic logic [2:0] count_low(input logic [COLS-1:0] c);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (!c[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  // Index of the lowest-numbered low column; only meaningful when one is low.
  function automatic logic [1:0] low_index(input logic [COLS-1:0] c);
    logic [1:0] idx;
    idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!c[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-level debouncer: a result is stable once DEBOUNCE consecutive frames
// have produced the same value.
module key_debounce
  import hex_keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_strobe,
  input  scan_result_t frame_result,
  output logic         stable_strobe,
  output scan_result_t stable_result
);

  logic [3:0]   stable_cnt;
  logic [3:0]   cnt_next;
  scan_result_t prev_result;

  always_comb begin
    cnt_next = 4'd1;
    if (frame_result == prev_result) begin
      cnt_next = (stable_cnt >= 4'(DEBOUNCE)) ? 4'(DEBOUNCE) : stable_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt    <= '0;
      prev_result   <= '{kind: NONE, code: '0};
      stable_strobe <= 1'b0;
      stable_result <= '{kind: NONE, code: '0};
    end else begin
      stable_strobe <= frame_strobe && (cnt_next == 4'(DEBOUNCE));
      if (frame_strobe) begin
        stable_cnt    <= cnt_next;
        prev_result   <= frame_result;
        stable_result <= frame_result;
      end
    end
  end

endmodule

// File: rtl/hex_keypad.sv
// 4x4 hex keypad scanner: row drive, column synchronizer, frame accumulation,
// debounced key acceptance and a 4-digit shift register for the display.
module hex_keypad
  import hex_keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  cols,
  input  logic        clear,
  output logic [3:0]  rows,
  output logic [15:0] data,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]    sync1, sync2;
  logic [DW-1:0] dwell;
  logic [1:0]    row;
  logic          last_dwell, frame_end;
  logic [1:0]    acc_n, merged_n;
  logic [3:0]    acc_code, merged_code;
  logic [2:0]    row_n, sum_n;
  scan_result_t  frame_res, stable_res;
  logic          stable_strobe;
  logic          last_valid;
  logic [3:0]    last_code;
  logic          accept, release_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= cols;
      sync2 <= sync1;
    end
  end

  assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
  assign frame_end  = last_dwell && (row == 2'd3);
  assign rows       = ~(4'b0001 << row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
      row   <= '0;
    end else if (last_dwell) begin
      dwell <= '0;
      row   <= row + 2'd1;
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Low-bit count saturates at 2 so MULTI is sticky for the rest of the frame.
  always_comb begin
    row_n       = count_low(sync2);
    sum_n       = {1'b0, acc_n} + row_n;
    merged_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    merged_code = acc_code;
    if (acc_n == 2'd0 && row_n == 3'd1) merged_code = {row, low_index(sync2)};
  end

  always_comb begin
    frame_res = '{kind: NONE, code: '0};
    if (merged_n == 2'd1)      frame_res = '{kind: KEY, code: merged_code};
    else if (merged_n == 2'd2) frame_res = '{kind: MULTI, code: '0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_n    <= '0;
      acc_code <= '0;
    end else if (frame_end) begin
      acc_n    <= '0;
      acc_code <= '0;
    end else if (last_dwell) begin
      acc_n    <= merged_n;
      acc_code <= merged_code;
    end
  end

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_strobe (frame_end),
    .frame_result (frame_res),
    .stable_strobe(stable_strobe),
    .stable_result(stable_res)
  );

  assign accept      = stable_strobe && (stable_res.kind == KEY) &&
                       (!last_valid || (last_code != stable_res.code));
  assign release_key = stable_strobe && (stable_res.kind == NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_held   <= 1'b0;
      last_valid <= 1'b0;
      last_code  <= '0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code   <= stable_res.code;
        last_code  <= stable_res.code;
        last_valid <= 1'b1;
        key_held   <= 1'b1;
      end else if (release_key) begin
        last_valid <= 1'b0;
        key_held   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clear) begin
      data <= accept ? {12'h000, stable_res.code} : '0;
    end else if (accept) begin
      data <= {data[11:0], stable_res.code};
    end
  end

endmodule

// File: tb/tb_hex_keypad.sv
// Scoreboard bench for hex_keypad: a frame-level keypad model predicts each
// accepted key; a monitor checks every key_valid pulse against the queue.
module tb_hex_keypad;

  localparam int SD    = 4;
  localparam int DEB   = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cols;
  logic        clear;
  logic [3:0]  rows;
  logic [15:0] data;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed;
  int          cyc;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    int code;
    int dat;
    int cycle;
  } exp_t;
  exp_t exp_q[$];

  int  hist[$];
  int  last_m, data_m, pending_res;
  bit  held_m, have_pending, pending_stable;

  hex_keypad #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cols     (cols),
    .clear    (clear),
    .rows     (rows),
    .data     (data),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its row line onto its column line.
  always_comb begin
    cols = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got key_valid code %0h expected no pulse (cycle %0d)",
                 key_code, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_code", int'(key_code), e.code);
        check("pulse_data", int'(data), e.dat);
        check("pulse_cycle", cyc, e.cycle);
      end
    end
  end

  // -1 = no key, -2 = several keys, otherwise the key index.
  function automatic int classify(input logic [15:0] s);
    int n, k;
    n = 0;
    k = -1;
    for (int i = 0; i < 16; i++)
      if (s[i]) begin
        n++;
        k = i;
      end
    if (n == 0) return -1;
    if (n > 1)  return -2;
    return k;
  endfunction

  task automatic model_reset();
    hist.delete();
    last_m       = -1;
    data_m       = 0;
    held_m       = 1'b0;
    have_pending = 1'b0;
  endtask

  task automatic model_apply(input bit clr);
    bit acc;
    acc = 1'b0;
    if (have_pending && pending_stable) begin
      if (pending_res >= 0 && pending_res != last_m) begin
        acc    = 1'b1;
        data_m = clr ? pending_res : (((data_m << 4) | pending_res) & 16'hFFFF);
        last_m = pending_res;
        held_m = 1'b1;
        exp_q.push_back('{code: pending_res, dat: data_m, cycle: cyc + 1});
      end else if (pending_res == -1) begin
        last_m = -1;
        held_m = 1'b0;
      end
    end
    if (clr && !acc) data_m = 0;
  endtask

  task automatic check_rows();
    logic [3:0] exp_rows;
    exp_rows = ~(4'b0001 << ((cyc / SD) % 4));
    check("rows", int'(rows), int'(exp_rows));
  endtask

  // Called at the negedge of a frame's first cycle.
  task automatic frame(input logic [15:0] set, input bit clr);
    int  res;
    bit  st;
    pressed = set;
    clear   = clr;
    model_apply(clr);
    res = classify(set);
    hist.push_back(res);
    st = (hist.size() >= DEB);
    if (st)
      for (int i = 1; i < DEB; i++)
        if (hist[hist.size()-1-i] != res) st = 1'b0;
    pending_res    = res;
    pending_stable = st;
    have_pending   = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_rows();
    check("held", int'(key_held), int'(held_m));
    check("data", int'(data), data_m);
    repeat (FRAME - 1) begin
      @(negedge clk);
      check_rows();
    end
  endtask

  task automatic press(input int k, input int n_on, input int n_off);
    logic [15:0] s;
    s = '0;
    s[k] = 1'b1;
    repeat (n_on)  frame(s, 1'b0);
    repeat (n_off) frame('0, 1'b0);
  endtask

  function automatic logic [15:0] key_set(input int a, input int b);
    logic [15:0] s;
    s = '0;
    if (a >= 0) s[a] = 1'b1;
    if (b >= 0) s[b] = 1'b1;
    return s;
  endfunction

  initial begin
    rst_n   = 1'b0;
    pressed = '0;
    clear   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_rows", int'(rows), 'hE);
    check("reset_data", int'(data), 0);
    check("reset_code", int'(key_code), 0);
    check("reset_valid", int'(key_valid), 0);
    check("reset_held", int'(key_held), 0);
    rst_n = 1'b1;

    // Idle scan
    repeat (4) frame('0, 1'b0);

    // Single key 9 held five frames, then released
    press(9, 5, 3);
    check("single_code", int'(key_code), 9);
    check("single_data", int'(data), 'h0009);

    // Digit sequence 1..5
    for (int k = 1; k <= 5; k++) press(k, 3, 3);
    check("seq_data", int'(data), 'h2345);
    check("seq_held", int'(key_held), 0);

    // Bounce: toggles every frame
    for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? key_set(3, -1) : '0, 1'b0);
    repeat (3) frame('0, 1'b0);

    // Overlap back to the same key, then to a different key
    repeat (3) frame(key_set(5, -1), 1'b0);
    repeat (3) frame(key_set(5, 12), 1'b0);
    repeat (3) frame(key_set(5, -1), 1'b0);
    repeat (3) frame(key_set(12, 5), 1'b0);
    repeat (3) frame(key_set(12, -1), 1'b0);
    check("multi_code", int'(key_code), 12);
    repeat (3) frame('0, 1'b0);

    // Clear coinciding with acceptance of key 7
    for (int k = 10; k <= 13; k++) press(k, 3, 2);
    check("pre_clear_data", int'(data), 'hABCD);
    frame(key_set(7, -1), 1'b0);
    frame(key_set(7, -1), 1'b0);
    frame(key_set(7, -1), 1'b1);
    check("clear_accept_data", int'(data), 'h0007);
    repeat (3) frame('0, 1'b0);

    // Reset in the middle of a frame while a key is held
    frame(key_set(6, -1), 1'b0);
    frame(key_set(6, -1), 1'b0);
    frame(key_set(6, -1), 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rows", int'(rows), 'hE);
    check("midrst_data", int'(data), 0);
    check("midrst_code", int'(key_code), 0);
    check("midrst_valid", int'(key_valid), 0);
    check("midrst_held", int'(key_held), 0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    check("midrst_rows_release", int'(rows), 'hE);
    repeat (3) frame(key_set(6, -1), 1'b0);
    repeat (3) frame('0, 1'b0);

    // Randomized segments
    for (int seg = 0; seg < 40; seg++) begin
      int          kind, a, b, len;
      logic [15:0] s;
      kind = int'($urandom_range(0, 3));
      a    = int'($urandom_range(0, 15));
      b    = (a + 1 + int'($urandom_range(0, 14))) % 16;
      len  = int'($urandom_range(1, 4));
      s    = (kind == 0) ? '0 : (kind == 3) ? key_set(a, b) : key_set(a, -1);
      for (int f = 0; f < len; f++) frame(s, ($urandom_range(0, 15) == 0));
    end

    repeat (3) frame('0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d outstanding expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
